// File: rtl/rmw_counter_1r1w_if.sv
// Signal bundle between the counter RMW initiator (master), its update client and the 1r1w memory
// atom (slave side). Clock and reset stay outside the bundle.
interface rmw_counter_1r1w_if #(
  parameter int unsigned BITADDR = 3,
  parameter int unsigned BITDATA = 8,
  parameter int unsigned BITINCR = 4
);

  logic               mem_ready;

  logic               upd_vld;
  logic               upd_rdy;
  logic [BITADDR-1:0] upd_adr;
  logic [BITINCR-1:0] upd_inc;

  logic               res_vld;
  logic [BITADDR-1:0] res_adr;
  logic [BITDATA-1:0] res_dout;
  logic               res_sat;

  logic               read_0;
  logic [BITADDR-1:0] rd_adr_0;
  logic [BITDATA-1:0] rd_dout_0;

  logic               write_1;
  logic [BITADDR-1:0] wr_adr_1;
  logic [BITDATA-1:0] wr_din_1;

  modport master (
    input  mem_ready,
    input  upd_vld,
    output upd_rdy,
    input  upd_adr,
    input  upd_inc,
    output res_vld,
    output res_adr,
    output res_dout,
    output res_sat,
    output read_0,
    output rd_adr_0,
    input  rd_dout_0,
    output write_1,
    output wr_adr_1,
    output wr_din_1
  );

  modport slave (
    output mem_ready,
    output upd_vld,
    input  upd_rdy,
    output upd_adr,
    output upd_inc,
    input  res_vld,
    input  res_adr,
    input  res_dout,
    input  res_sat,
    input  read_0,
    input  rd_adr_0,
    output rd_dout_0,
    input  write_1,
    input  wr_adr_1,
    input  wr_din_1
  );

endinterface

// File: rtl/rmw_counter_1r1w.sv
// Read-modify-write counter engine on a 1r1w memory: one increment per cycle, write-back after the
// read latency, in-flight forwarding, and a zeroing sweep whenever the memory becomes ready.
module rmw_counter_1r1w #(
  parameter int unsigned NUMADDR    = 8,
  parameter int unsigned BITADDR    = 3,
  parameter int unsigned BITDATA    = 8,
  parameter int unsigned BITINCR    = 4,
  parameter int unsigned SRAM_DELAY = 0,
  parameter int unsigned SATURATE   = 1
) (
  input logic                clk,
  input logic                rst,
  rmw_counter_1r1w_if.master bus
);

  typedef enum logic [1:0] {StWait, StInit, StRun} state_e;

  state_e             state_q, state_d;
  logic [BITADDR-1:0] init_adr_q, init_adr_d;

  logic               upd_rdy;
  logic               upd_acc;

  // Final pipeline stage: the update whose read data is on rd_dout_0 this cycle.
  logic               st_vld;
  logic [BITADDR-1:0] st_adr;
  logic [BITINCR-1:0] st_inc;

  logic               fwd_hit;
  logic [BITDATA-1:0] fwd_dat;
  logic               pipe_busy;

  logic [BITDATA-1:0] old_val;
  logic [BITDATA:0]   sum;
  logic [BITDATA-1:0] result;

  logic               wr_vld;
  logic [BITADDR-1:0] wr_adr;
  logic [BITDATA-1:0] wr_dat;

  assign upd_rdy = (state_q == StRun) && bus.mem_ready;
  assign upd_acc = bus.upd_vld && upd_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StWait;
      init_adr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_adr_q <= init_adr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_adr_d = init_adr_q;
    unique case (state_q)
      StWait: begin
        // Let in-flight write-backs finish first so the sweep owns the write port.
        if (bus.mem_ready && !pipe_busy) begin
          state_d    = StInit;
          init_adr_d = '0;
        end
      end
      StInit: begin
        if (init_adr_q == BITADDR'(NUMADDR - 1)) begin
          state_d    = StRun;
          init_adr_d = '0;
        end else begin
          init_adr_d = init_adr_q + 1'b1;
        end
      end
      StRun: begin
        if (!bus.mem_ready) begin
          state_d = StWait;
        end
      end
      default: state_d = StWait;
    endcase
  end

  if (SRAM_DELAY == 0) begin : g_no_delay
    assign st_vld    = upd_acc;
    assign st_adr    = bus.upd_adr;
    assign st_inc    = bus.upd_inc;
    assign fwd_hit   = 1'b0;
    assign fwd_dat   = '0;
    assign pipe_busy = 1'b0;
  end else begin : g_delay
    logic [SRAM_DELAY-1:0] vld_q;
    logic [BITADDR-1:0]    adr_q [SRAM_DELAY];
    logic [BITINCR-1:0]    inc_q [SRAM_DELAY];
    // Write history: entry 0 is last cycle's write, entry SRAM_DELAY-1 the oldest kept.
    logic [SRAM_DELAY-1:0] wh_vld_q;
    logic [BITADDR-1:0]    wh_adr_q [SRAM_DELAY];
    logic [BITDATA-1:0]    wh_dat_q [SRAM_DELAY];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q    <= '0;
        wh_vld_q <= '0;
        for (int k = 0; k < SRAM_DELAY; k++) begin
          adr_q[k]    <= '0;
          inc_q[k]    <= '0;
          wh_adr_q[k] <= '0;
          wh_dat_q[k] <= '0;
        end
      end else begin
        vld_q[0]    <= upd_acc;
        adr_q[0]    <= bus.upd_adr;
        inc_q[0]    <= bus.upd_inc;
        wh_vld_q[0] <= wr_vld;
        wh_adr_q[0] <= wr_adr;
        wh_dat_q[0] <= wr_dat;
        for (int k = 1; k < SRAM_DELAY; k++) begin
          vld_q[k]    <= vld_q[k-1];
          adr_q[k]    <= adr_q[k-1];
          inc_q[k]    <= inc_q[k-1];
          wh_vld_q[k] <= wh_vld_q[k-1];
          wh_adr_q[k] <= wh_adr_q[k-1];
          wh_dat_q[k] <= wh_dat_q[k-1];
        end
      end
    end

    assign st_vld    = vld_q[SRAM_DELAY-1];
    assign st_adr    = adr_q[SRAM_DELAY-1];
    assign st_inc    = inc_q[SRAM_DELAY-1];
    assign pipe_busy = |vld_q;

    // History covers exactly the writes the memory read missed; oldest first so the youngest wins.
    always_comb begin
      fwd_hit = 1'b0;
      fwd_dat = '0;
      for (int j = SRAM_DELAY - 1; j >= 0; j--) begin
        if (wh_vld_q[j] && (wh_adr_q[j] == st_adr)) begin
          fwd_hit = 1'b1;
          fwd_dat = wh_dat_q[j];
        end
      end
    end
  end

  always_comb begin
    old_val = fwd_hit ? fwd_dat : bus.rd_dout_0;
    sum     = {1'b0, old_val} + {{(BITDATA + 1 - BITINCR){1'b0}}, st_inc};
    result  = sum[BITDATA-1:0];
    if ((SATURATE != 0) && sum[BITDATA]) begin
      result = '1;
    end
  end

  always_comb begin
    wr_vld = 1'b0;
    wr_adr = '0;
    wr_dat = '0;
    if (state_q == StInit) begin
      wr_vld = 1'b1;
      wr_adr = init_adr_q;
    end else if (st_vld) begin
      wr_vld = 1'b1;
      wr_adr = st_adr;
      wr_dat = result;
    end
  end

  assign bus.upd_rdy  = upd_rdy;
  assign bus.read_0   = upd_acc;
  assign bus.rd_adr_0 = upd_acc ? bus.upd_adr : '0;

  assign bus.write_1  = wr_vld;
  assign bus.wr_adr_1 = wr_adr;
  assign bus.wr_din_1 = wr_dat;

  assign bus.res_vld  = st_vld;
  assign bus.res_adr  = st_vld ? st_adr : '0;
  assign bus.res_dout = st_vld ? result : '0;
  assign bus.res_sat  = st_vld && sum[BITDATA];

endmodule

// File: tb/tb_rmw_counter_1r1w.sv
// Bench: three counter instances (delay 2 saturating, delay 1 wrapping, delay 0 saturating) share
// one stimulus stream; each has its own memory model, reference counters and result scoreboard.
module tb_rmw_counter_1r1w;

  typedef struct packed {
    logic [2:0] adr;
    logic [7:0] dout;
    logic       sat;
    int         due;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_ready;
  logic       upd_vld;
  logic [2:0] upd_adr;
  logic [3:0] upd_inc;

  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  int   rdy_expect;
  int   sweep_expect;
  logic chk_zero;
  logic model_clr;
  logic mem_chk;
  logic end_chk;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned D   = (g == 0) ? 2 : ((g == 1) ? 1 : 0);
    localparam int unsigned SAT = (g == 1) ? 0 : 1;

    rmw_counter_1r1w_if #(.BITADDR(3), .BITDATA(8), .BITINCR(4)) bus ();

    rmw_counter_1r1w #(
      .NUMADDR   (8),
      .BITADDR   (3),
      .BITDATA   (8),
      .BITINCR   (4),
      .SRAM_DELAY(D),
      .SATURATE  (SAT)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.mem_ready = mem_ready;
    assign bus.upd_vld   = upd_vld;
    assign bus.upd_adr   = upd_adr;
    assign bus.upd_inc   = upd_inc;

    logic [7:0] mem   [8];
    logic [7:0] model [8];
    res_t       sb_q  [$];

    initial for (int a = 0; a < 8; a++) mem[a] = 8'hA5;

    always @(posedge clk) begin
      if (bus.write_1) mem[bus.wr_adr_1] <= bus.wr_din_1;
    end

    if (D == 0) begin : g_comb
      assign bus.rd_dout_0 = bus.read_0 ? mem[bus.rd_adr_0] : 8'hEE;
    end else begin : g_pipe
      logic [7:0] rdp [4];
      always @(posedge clk) begin
        rdp[0] <= bus.read_0 ? mem[bus.rd_adr_0] : 8'hEE;
        for (int k = 1; k < 4; k++) rdp[k] <= rdp[k-1];
      end
      assign bus.rd_dout_0 = rdp[D-1];
    end

    always @(negedge rst) begin
      sb_q.delete();
      #1;
      check_val($sformatf("rst_res_vld i%0d", g), int'(bus.res_vld), 0);
      check_val($sformatf("rst_write i%0d", g), int'(bus.write_1), 0);
      check_val($sformatf("rst_read i%0d", g), int'(bus.read_0), 0);
      check_val($sformatf("rst_rd_adr i%0d", g), int'(bus.rd_adr_0), 0);
      check_val($sformatf("rst_upd_rdy i%0d", g), int'(bus.upd_rdy), 0);
    end

    always @(negedge clk) begin : p_sb
      res_t       e;
      logic [8:0] s;
      if (model_clr) for (int a = 0; a < 8; a++) model[a] = 8'h00;
      if (upd_vld && rdy_expect == 1) begin
        s      = {1'b0, model[upd_adr]} + {5'b0, upd_inc};
        e.adr  = upd_adr;
        e.sat  = s[8];
        e.dout = (s[8] && SAT != 0) ? 8'hFF : s[7:0];
        e.due  = cyc + D;
        model[upd_adr] = e.dout;
        sb_q.push_back(e);
      end
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        check_val($sformatf("res_missing i%0d adr%0d", g, sb_q[0].adr), 0, 1);
        void'(sb_q.pop_front());
      end
      if (bus.res_vld) begin
        if (sb_q.size() == 0) begin
          check_val($sformatf("res_stale i%0d", g), 1, 0);
        end else begin
          e = sb_q.pop_front();
          check_val($sformatf("res_time i%0d", g), cyc, e.due);
          check_val($sformatf("res_adr i%0d", g), int'(bus.res_adr), int'(e.adr));
          check_val($sformatf("res_dout i%0d", g), int'(bus.res_dout), int'(e.dout));
          check_val($sformatf("res_sat i%0d", g), int'(bus.res_sat), int'(e.sat));
        end
      end
      if (rdy_expect >= 0) check_val($sformatf("upd_rdy i%0d", g), int'(bus.upd_rdy), rdy_expect);
      if (sweep_expect >= 0) begin
        check_val($sformatf("init_write i%0d", g), int'(bus.write_1), 1);
        check_val($sformatf("init_adr i%0d", g), int'(bus.wr_adr_1), sweep_expect);
        check_val($sformatf("init_din i%0d", g), int'(bus.wr_din_1), 0);
        check_val($sformatf("init_read i%0d", g), int'(bus.read_0), 0);
      end
      if (chk_zero) begin
        check_val($sformatf("idle_write i%0d", g), int'(bus.write_1), 0);
        check_val($sformatf("idle_wr_adr i%0d", g), int'(bus.wr_adr_1), 0);
        check_val($sformatf("idle_wr_din i%0d", g), int'(bus.wr_din_1), 0);
        check_val($sformatf("idle_read i%0d", g), int'(bus.read_0), 0);
        check_val($sformatf("idle_res_vld i%0d", g), int'(bus.res_vld), 0);
      end
      if (mem_chk) begin
        for (int a = 0; a < 8; a++) begin
          check_val($sformatf("mem%0d i%0d", a, g), int'(mem[a]), int'(model[a]));
        end
      end
      if (end_chk) check_val($sformatf("sb_drain i%0d", g), sb_q.size(), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int adr, input int inc);
    upd_vld = 1'b1;
    upd_adr = 3'(adr);
    upd_inc = 4'(inc);
    tick();
  endtask

  task automatic idle(input int n);
    upd_vld = 1'b0;
    repeat (n) tick();
  endtask

  task automatic mem_check();
    mem_chk = 1'b1;
    tick();
    mem_chk = 1'b0;
  endtask

  // Entered during the last WAIT cycle; returns in the first RUN cycle.
  task automatic sweep();
    tick();
    model_clr = 1'b0;
    chk_zero  = 1'b0;
    for (int a = 0; a < 8; a++) begin
      sweep_expect = a;
      tick();
    end
    sweep_expect = -1;
    rdy_expect   = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    mem_ready    = 1'b0;
    upd_vld      = 1'b0;
    upd_adr      = '0;
    upd_inc      = '0;
    rdy_expect   = 0;
    sweep_expect = -1;
    chk_zero     = 1'b1;
    model_clr    = 1'b1;
    mem_chk      = 1'b0;
    end_chk      = 1'b0;
    repeat (3) tick();

    // Reset release: zeroing sweep then ready.
    mem_ready = 1'b1;
    rst       = 1'b1;
    sweep();
    mem_check();

    // Same address back to back.
    repeat (4) send(5, 3);
    idle(4);
    mem_check();

    // Drive adr 1 to 250, then overflow, then hold at the limit.
    repeat (16) send(1, 15);
    send(1, 10);
    send(1, 9);
    send(1, 1);
    send(1, 0);
    idle(4);
    mem_check();

    // Interleaved addresses.
    send(2, 1);
    send(3, 2);
    send(2, 4);
    send(3, 8);
    idle(4);
    mem_check();

    // Random traffic with gaps.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else send(int'($urandom_range(7)), int'($urandom_range(15)));
    end
    idle(4);
    mem_check();

    // Memory not ready for 3 cycles: in-flight work drains, then the sweep repeats.
    repeat (3) send(4, 1);
    mem_ready  = 1'b0;
    rdy_expect = 0;
    upd_vld    = 1'b1;
    upd_adr    = 3'd6;
    upd_inc    = 4'd5;
    repeat (3) tick();
    mem_ready = 1'b1;
    upd_vld   = 1'b0;
    model_clr = 1'b1;
    sweep();
    mem_check();
    send(4, 2);
    idle(4);

    // Reset mid-stream.
    send(7, 3);
    send(7, 3);
    rst        = 1'b0;
    rdy_expect = 0;
    chk_zero   = 1'b1;
    model_clr  = 1'b1;
    tick();
    upd_vld = 1'b0;
    tick();
    rst = 1'b1;
    sweep();
    mem_check();
    send(7, 5);
    send(0, 1);
    send(7, 15);
    idle(4);
    mem_check();

    end_chk = 1'b1;
    tick();
    end_chk = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
